contador_bcd_updown: RTL

Parametrised multi-digit BCD up/down counter with enable, synchronous parallel load, wrap or saturate mode, terminal-count output for cascading, and a sticky overflow flag. Each decimal digit is a mod-10 cell, and the cells are chained by a ripple enable. The block drives the 7-segment display multiplexer and can be cascaded with further instances through `tc`.

---
 rtl/contador_bcd_updown_pkg.sv | 12 +
 rtl/contador_bcd_updown_if.sv | 27 ++
 rtl/contador_bcd_updown_digito.sv | 34 +++
 rtl/contador_bcd_updown.sv | 74 +++++++
 4 files changed

// File: rtl/contador_bcd_updown_pkg.sv
// Shared constants and helpers for the BCD up/down counter and its digit cells.
package contador_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Any nibble above 9 is forced to 9 so a load can never leave a non-BCD digit.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/contador_bcd_updown_if.sv
// Control and data bundle of the BCD counter.
// There is no valid/ready handshake: en, up and load are level controls
// sampled on every rising edge, q and ovf are registered, and the three
// tick outputs are combinational from q, en, up and load.
interface contador_bcd_updown_if #(
    parameter int DIGITS = 3
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   d;
    logic [4*DIGITS-1:0]   q;
    logic                  max_tick;
    logic                  min_tick;
    logic                  tc;
    logic                  ovf;

    modport master (
        output en, up, load, d,
        input  q, max_tick, min_tick, tc, ovf
    );

    modport slave (
        input  en, up, load, d,
        output q, max_tick, min_tick, tc, ovf
    );
endinterface

// File: rtl/contador_bcd_updown_digito.sv
// One mod-10 BCD cell: loads a clamped nibble, or steps up/down when told to.
module digito_bcd
    import contador_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       step,
    input  logic       up,
    output logic [3:0] q,
    output logic       at_max,
    output logic       at_min
);

    // Digit register: reset > load > step > hold, rolling 9->0 up and 0->9 down.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= clamp_bcd(d);
        end else if (step) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    assign at_max = (q == BCD_MAX);
    assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/contador_bcd_updown.sv
// Multi-digit BCD up/down counter: chain of mod-10 cells linked by a ripple
// step enable, with wrap or saturate behaviour at the limits, a terminal
// count for cascading and a sticky overflow flag.
module contador_bcd_updown
    import contador_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    contador_bcd_updown_if.slave  bus
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic              at_limit;
    logic              step0;
    logic              ovf_r;

    // The limit is direction dependent: all nines going up, all zeros going down.
    assign at_limit = bus.up ? (&at_max) : (&at_min);

    // In saturate mode the whole chain is frozen once the limit is reached.
    assign step0 = bus.en & ~bus.load & (WRAP ? 1'b1 : ~at_limit);

    // Carry/borrow ripple. Each digit steps when every lower digit sits at its
    // directional limit; written as a prefix AND of the lower cells' flags,
    // which is the same as step[i] = step[i-1] & flag[i-1] unrolled.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_step
            if (i == 0) begin : g_lsd
                assign step[i] = step0;
            end else begin : g_upper
                assign step[i] = step0 & (bus.up ? (&at_max[i-1:0]) : (&at_min[i-1:0]));
            end
        end
    endgenerate

    // One BCD cell per decimal digit, digit 0 least significant.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dig
            digito_bcd u_digito (
                .clk    (clk),
                .reset  (reset),
                .load   (bus.load),
                .d      (bus.d[4*i +: 4]),
                .step   (step[i]),
                .up     (bus.up),
                .q      (bus.q[4*i +: 4]),
                .at_max (at_max[i]),
                .at_min (at_min[i])
            );
        end
    endgenerate

    // Sticky overflow: set on any wrap/saturate event, cleared only by reset or load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (bus.load) begin
            ovf_r <= 1'b0;
        end else if (bus.en && at_limit) begin
            ovf_r <= 1'b1;
        end
    end

    assign bus.max_tick = &at_max;
    assign bus.min_tick = &at_min;
    assign bus.tc       = bus.en & ~bus.load & at_limit;
    assign bus.ovf      = ovf_r;

endmodule
